sha3_depadder: RTL
==================

SHA3_DEPADDER -- requirements
Module: sha3_depadder

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous active-high reset.
REQ-003 The block SHALL have the port in, input, 32 bits: padded rate word; byte 0 is in[31:24].
REQ-004 The block SHALL have the port in_valid, input, 1 bit: the in word is valid.
REQ-005 The block SHALL have the port in_last, input, 1 bit: sampled with word 17 of a block; 1 marks the final, padded block.
REQ-006 The block SHALL have the port in_ready, output, 1 bit: the block accepts an input word.
REQ-007 The block SHALL have the port out, output, 32 bits: message word; invalid bytes are zero.
REQ-008 The block SHALL have the port out_valid, output, 1 bit: the out word is valid.
REQ-009 The block SHALL have the port out_ready, input, 1 bit: downstream accepts the out word.
REQ-010 The block SHALL have the port out_last, output, 1 bit: out is the final message word.
REQ-011 The block SHALL have the port out_byte_num, output, 2 bits: valid bytes in the final word (0..3); it is 0 when out_last=0.
REQ-012 The block SHALL have the port err, output, 1 bit: one-cycle pulse on malformed padding.

Function
REQ-013 Block size SHALL be 18 words, 576 bits, 72 bytes: the SHA3-512 rate. Byte b lives in word b/4 at byte position b%4.
REQ-014 A transfer SHALL occur only when valid and ready are both 1 on the same edge.
REQ-015 State FILL SHALL hold in_ready=1 and store words 0..17 into an internal buffer using a 5-bit word counter.
REQ-016 On the word-17 handshake, FILL SHALL go to EMIT if in_last=0 and to SCAN if in_last=1; in_ready SHALL drop on the following cycle.
REQ-017 In SCAN, each cycle SHALL inspect one word, from word 17 downward, with bit 7 of byte 71 masked off.
REQ-018 SCAN SHALL stop at the first word containing a nonzero byte. Pad position p is the highest nonzero byte index. Message length L = p.
REQ-019 SCAN latency SHALL be 18-k cycles, where k is the word containing p.
REQ-020 If words 17..0 are all zero after masking, SCAN SHALL set p=0.
REQ-021 EMIT for a non-last block SHALL output words 0..17 in order with out_last=0.
REQ-022 EMIT for a last block SHALL output words 0..L/4-1 unchanged, then word L/4 with bytes at index L%4 and above zeroed, out_last=1, out_byte_num=L%4.
REQ-023 When L%4=0, a final word of 0x00000000 with out_byte_num=0 SHALL still be emitted.
REQ-024 While out_valid=1 and out_ready=0, out, out_last and out_byte_num SHALL be held stable.
REQ-025 After the final EMIT handshake, the block SHALL return to FILL on the next cycle.
REQ-026 FILL and EMIT SHALL never overlap: a single buffer, no input accepted during SCAN or EMIT.

Reset
REQ-027 Reset SHALL force state FILL, the word counter to 0, and in_ready=1.
REQ-028 Reset SHALL force out_valid=0, out_last=0, out_byte_num=0, out=0 and err=0.
REQ-029 Reset asserted mid-FILL, mid-SCAN or mid-EMIT SHALL discard the partial block; the buffer contents are don't-care.

Configuration
REQ-030 With macro SHA3_DEPADDER_CHECK_EN defined, SCAN SHALL validate that bit 7 of byte 71 is 1.
REQ-031 With SHA3_DEPADDER_CHECK_EN defined, SCAN SHALL validate that byte p equals 0x06 after masking; when p=71, byte 71 must therefore be 0x86.
REQ-032 With SHA3_DEPADDER_CHECK_EN defined, any validation failure, including the all-zero case of REQ-020, SHALL pulse err for one cycle, emit nothing, and return to FILL.
REQ-033 Without SHA3_DEPADDER_CHECK_EN, err SHALL be tied to 0 and p SHALL be computed by REQ-018 and REQ-020 only.

Verification
REQ-034 Last block: word0=0x90ABCD06, words1..16=0, word17=0x00000080 -> one output 0x90ABCD00 with out_last=1 and out_byte_num=3, after 18 SCAN cycles.
REQ-035 Empty message: word0=0x06000000, word17=0x00000080, rest 0 -> one output 0x00000000 with out_last=1 and out_byte_num=0.
REQ-036 p=71: words0..16=0x11111111, word17=0x22222286 -> 17 words of 0x11111111, then 0x22222200 with out_last=1 and out_byte_num=3; SCAN takes 1 cycle.
REQ-037 Non-last block of 18 words of 0xA5A5A5A5 with in_last=0, then the REQ-034 block -> 18 words with out_last=0, then the REQ-034 output; out_ready toggled every other cycle gives no loss or duplication.
REQ-038 CHECK_EN defined: last block with word17=0x00000000, or word0=0x90ABCD05 -> err pulse, no out_valid, in_ready=1 again.
REQ-039 Reset asserted on the 9th EMIT word -> all outputs 0 in the same cycle; a fresh REQ-034 block then decodes correctly.

Source files
------------

// File: rtl/sha3_depadder_if.sv
// Stream bundle between a padded-block producer and the sha3_depadder message sink.
// Latency: none, wires only.
// Backpressure: valid/ready on both the input and output streams; err is a bare pulse.
interface sha3_depadder_if;
    logic [31:0] in;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [1:0]  out_byte_num;
    logic        err;

    modport master (
        output in, in_valid, in_last, out_ready,
        input  in_ready, out, out_valid, out_last, out_byte_num, err
    );

    modport slave (
        input  in, in_valid, in_last, out_ready,
        output in_ready, out, out_valid, out_last, out_byte_num, err
    );
endinterface

// File: rtl/sha3_depadder.sv
// SHA3-512 rate-block depadder: buffers 18 words and strips the padding of the last block (SHA3_DEPADDER_CHECK_EN adds pad validation and err).
// Latency: non-last block emits 1 cycle after word 17; last block emits after 18-k scan cycles (k = word holding the pad byte).
// Backpressure: in_ready is low from word 17 until the final output handshake; outputs hold while out_ready is low.
module sha3_depadder (
    input  logic           clk,
    input  logic           reset,
    sha3_depadder_if.slave bus
);
    localparam int unsigned WORDS    = 18;
    localparam logic [4:0]  LAST_IDX = 5'd17;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  fin_idx_q, fin_idx_d;
    logic [1:0]  nb_q, nb_d;
    logic        last_blk_q, last_blk_d;
    logic        in_ready_q, in_ready_d;
    logic [31:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [1:0]  out_byte_num_q, out_byte_num_d;

    logic [31:0] mem_q [WORDS];

    logic        in_fire;
    logic        out_fire;
    logic [31:0] scan_word;
    logic        scan_found;
    logic [1:0]  scan_pos;
    logic [4:0]  emit_nxt;
    logic        nxt_final;

    // Keep the first n bytes (byte 0 is the MSB end) and zero the rest.
    function automatic logic [31:0] keep_bytes(input logic [31:0] w, input logic [1:0] n);
        logic [31:0] r;
        case (n)
            2'd0:    r = 32'h0;
            2'd1:    r = {w[31:24], 24'h0};
            2'd2:    r = {w[31:16], 16'h0};
            default: r = {w[31:8], 8'h0};
        endcase
        return r;
    endfunction

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;
    assign emit_nxt = cnt_q + 5'd1;
    assign nxt_final = last_blk_q && (emit_nxt == fin_idx_q);

    // The top bit of byte 71 is the closing pad bit, never message data.
    always_comb begin
        scan_word = mem_q[cnt_q];
        if (cnt_q == LAST_IDX) begin
            scan_word[7] = 1'b0;
        end
    end

    assign scan_found = |scan_word;

    always_comb begin
        scan_pos = 2'd0;
        if (scan_word[7:0] != 8'h00) begin
            scan_pos = 2'd3;
        end else if (scan_word[15:8] != 8'h00) begin
            scan_pos = 2'd2;
        end else if (scan_word[23:16] != 8'h00) begin
            scan_pos = 2'd1;
        end
    end

`ifdef SHA3_DEPADDER_CHECK_EN
    logic       err_q, err_d;
    logic [7:0] scan_byte;
    logic       scan_bad;

    always_comb begin
        case (scan_pos)
            2'd0:    scan_byte = scan_word[31:24];
            2'd1:    scan_byte = scan_word[23:16];
            2'd2:    scan_byte = scan_word[15:8];
            default: scan_byte = scan_word[7:0];
        endcase
    end

    assign scan_bad = ((cnt_q == LAST_IDX) && !mem_q[LAST_IDX][7])
                    || (!scan_found && (cnt_q == 5'd0))
                    || (scan_found && (scan_byte != 8'h06));
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        fin_idx_d      = fin_idx_q;
        nb_d           = nb_q;
        last_blk_d     = last_blk_q;
        in_ready_d     = in_ready_q;
        out_d          = out_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        out_byte_num_d = out_byte_num_q;
`ifdef SHA3_DEPADDER_CHECK_EN
        err_d          = 1'b0;
`endif
        case (state_q)
            FILL: begin
                if (in_fire) begin
                    if (cnt_q == LAST_IDX) begin
                        in_ready_d = 1'b0;
                        last_blk_d = bus.in_last;
                        if (bus.in_last) begin
                            state_d = SCAN;
                            cnt_d   = LAST_IDX;
                        end else begin
                            // Word 0 is already buffered, so the first beat can be presented at once.
                            state_d        = EMIT;
                            cnt_d          = 5'd0;
                            fin_idx_d      = LAST_IDX;
                            nb_d           = 2'd0;
                            out_d          = mem_q[0];
                            out_valid_d    = 1'b1;
                            out_last_d     = 1'b0;
                            out_byte_num_d = 2'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            SCAN: begin
                // Reaching word 0 with nothing found means p = 0: an empty message.
                if (scan_found || (cnt_q == 5'd0)) begin
                    state_d        = EMIT;
                    cnt_d          = 5'd0;
                    fin_idx_d      = cnt_q;
                    nb_d           = scan_pos;
                    out_valid_d    = 1'b1;
                    out_d          = (cnt_q == 5'd0) ? keep_bytes(mem_q[0], scan_pos) : mem_q[0];
                    out_last_d     = (cnt_q == 5'd0);
                    out_byte_num_d = (cnt_q == 5'd0) ? scan_pos : 2'd0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
`ifdef SHA3_DEPADDER_CHECK_EN
                if (scan_bad) begin
                    state_d        = FILL;
                    cnt_d          = 5'd0;
                    in_ready_d     = 1'b1;
                    out_valid_d    = 1'b0;
                    out_d          = 32'h0;
                    out_last_d     = 1'b0;
                    out_byte_num_d = 2'd0;
                    err_d          = 1'b1;
                end
`endif
            end
            EMIT: begin
                if (out_fire) begin
                    if (cnt_q == fin_idx_q) begin
                        state_d        = FILL;
                        cnt_d          = 5'd0;
                        in_ready_d     = 1'b1;
                        out_valid_d    = 1'b0;
                        out_d          = 32'h0;
                        out_last_d     = 1'b0;
                        out_byte_num_d = 2'd0;
                    end else begin
                        cnt_d          = emit_nxt;
                        out_d          = nxt_final ? keep_bytes(mem_q[emit_nxt], nb_q) : mem_q[emit_nxt];
                        out_last_d     = nxt_final;
                        out_byte_num_d = nxt_final ? nb_q : 2'd0;
                    end
                end
            end
            default: begin
                state_d    = FILL;
                cnt_d      = 5'd0;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= FILL;
            cnt_q          <= 5'd0;
            fin_idx_q      <= 5'd0;
            nb_q           <= 2'd0;
            last_blk_q     <= 1'b0;
            in_ready_q     <= 1'b1;
            out_q          <= 32'h0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_byte_num_q <= 2'd0;
`ifdef SHA3_DEPADDER_CHECK_EN
            err_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fin_idx_q      <= fin_idx_d;
            nb_q           <= nb_d;
            last_blk_q     <= last_blk_d;
            in_ready_q     <= in_ready_d;
            out_q          <= out_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            out_byte_num_q <= out_byte_num_d;
`ifdef SHA3_DEPADDER_CHECK_EN
            err_q          <= err_d;
`endif
        end
    end

    // Block buffer needs no reset: a partial block is simply overwritten.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[cnt_q] <= bus.in;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out          = out_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_byte_num = out_byte_num_q;
endmodule
